// File: rtl/sample_pkg.sv
// Sample format shared by the envelope decimator, minmax_filter and the capture path.
package sample_pkg;

    localparam int SAMPLE_DATA_WIDTH = 8;

    typedef logic signed [SAMPLE_DATA_WIDTH-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = sample_t'((2 ** (SAMPLE_DATA_WIDTH - 1)) - 1);
    localparam sample_t SAMPLE_MIN = sample_t'(-(2 ** (SAMPLE_DATA_WIDTH - 1)));

endpackage

// File: rtl/abs_sat.sv
// Saturating absolute value: the most-negative code maps to the largest positive code.
module abs_sat
    import sample_pkg::*;
#(
    parameter int WIDTH = SAMPLE_DATA_WIDTH
) (
    input  logic signed [WIDTH-1:0] a_i,
    output logic        [WIDTH-1:0] y_o
);

    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    always_comb begin
        // NOTE: output gets a default before any branch so no latch is inferred.
        y_o = a_i;
        if (a_i[WIDTH-1]) begin
            y_o = (a_i == MOST_NEG) ? MAX_POS : -a_i;
        end
    end

endmodule

// File: rtl/envelope_decimator.sv
// Rectifies incoming samples and emits the floor-average of each 2^LOG2_DECIMATION block.
module envelope_decimator #(
    parameter int SAMPLE_DATA_WIDTH = sample_pkg::SAMPLE_DATA_WIDTH,
    parameter int LOG2_DECIMATION   = 8,
    parameter int RECTIFY           = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                axiiv,
    input  logic signed [SAMPLE_DATA_WIDTH-1:0] axiid,
    output logic                                axiov,
    output logic        [SAMPLE_DATA_WIDTH-1:0] axiod
);

    localparam int W  = SAMPLE_DATA_WIDTH;
    localparam int AW = SAMPLE_DATA_WIDTH + LOG2_DECIMATION;
    localparam int CW = (LOG2_DECIMATION > 0) ? LOG2_DECIMATION : 1;

    logic        [W-1:0]  mag;
    logic signed [W-1:0]  r;
    logic signed [AW-1:0] sum;
    logic                 terminal;

    logic signed [AW-1:0] acc_q,   acc_d;
    logic        [CW-1:0] cnt_q,   cnt_d;
    logic                 axiov_q, axiov_d;
    logic        [W-1:0]  axiod_q, axiod_d;

    abs_sat #(.WIDTH(W)) u_abs_sat (
        .a_i(axiid),
        .y_o(mag)
    );

    assign r = (RECTIFY != 0) ? signed'(mag) : axiid;

    // The accumulator is W+L bits wide, so a full block of extreme samples cannot overflow.
    always_comb begin
        sum      = acc_q + AW'(r);
        terminal = (LOG2_DECIMATION == 0) || (&cnt_q);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        axiov_d  = 1'b0;
        axiod_d  = axiod_q;
        if (axiiv) begin
            if (terminal) begin
                acc_d   = '0;
                cnt_d   = '0;
                axiov_d = 1'b1;
                axiod_d = W'(sum >>> LOG2_DECIMATION);
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            axiov_q <= 1'b0;
            axiod_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;

endmodule

// File: tb/tb_envelope_decimator.sv
// Scoreboard bench: four decimator configurations checked against a block-average model.
module tb_envelope_decimator;

    localparam int N = 4;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        axiiv;
    logic [N-1:0][7:0]   axiid;
    logic [N-1:0]        axiov;
    logic [N-1:0][7:0]   axiod;

    exp_t exp_q [N][$];
    int   blk_sum [N];
    int   blk_n   [N];
    int   last_out[N];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    envelope_decimator #(.LOG2_DECIMATION(2), .RECTIFY(1)) u_l2 (
        .clk(clk), .rst(rst), .axiiv(axiiv[0]), .axiid(axiid[0]), .axiov(axiov[0]), .axiod(axiod[0]));
    envelope_decimator #(.LOG2_DECIMATION(1), .RECTIFY(0)) u_s1 (
        .clk(clk), .rst(rst), .axiiv(axiiv[1]), .axiid(axiid[1]), .axiov(axiov[1]), .axiod(axiod[1]));
    envelope_decimator #(.LOG2_DECIMATION(8), .RECTIFY(1)) u_l8 (
        .clk(clk), .rst(rst), .axiiv(axiiv[2]), .axiid(axiid[2]), .axiov(axiov[2]), .axiod(axiod[2]));
    envelope_decimator #(.LOG2_DECIMATION(0), .RECTIFY(1)) u_l0 (
        .clk(clk), .rst(rst), .axiiv(axiiv[3]), .axiid(axiid[3]), .axiov(axiov[3]), .axiod(axiod[3]));

    function automatic int lg(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic bit rect_mode(input int i);
        return i != 1;
    endfunction

    function automatic int rectify(input int i, input int x);
        if (rect_mode(i) && x < 0) return (x == -128) ? 127 : -x;
        return x;
    endfunction

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int shown(input int i, input logic [7:0] v);
        return rect_mode(i) ? int'(v) : int'(signed'(v));
    endfunction

    task automatic check(input string name, input int idx, input bit ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s inst%0d cyc%0d: got %0d, expected %0d", name, idx, cyc, act, req);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            blk_sum[i] = 0;
            blk_n[i]   = 0;
            exp_q[i].delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int v);
        exp_t e;
        axiiv[i] = 1'b1;
        axiid[i] = 8'(v);
        @(posedge clk);
        #1;
        axiiv[i] = 1'b0;
        axiid[i] = 8'($urandom);
        blk_sum[i] += rectify(i, v);
        blk_n[i]++;
        if (blk_n[i] == (1 << lg(i))) begin
            e.val = floor_div(blk_sum[i], 1 << lg(i));
            e.due = cyc;
            exp_q[i].push_back(e);
            blk_sum[i] = 0;
            blk_n[i]   = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                check("reset_valid", i, axiov[i] == 1'b0, int'(axiov[i]), 0);
                check("reset_data", i, axiod[i] == 8'd0, int'(axiod[i]), 0);
                last_out[i] = 0;
            end else if (axiov[i]) begin
                if (exp_q[i].size() == 0) begin
                    check("unexpected_pulse", i, 1'b0, shown(i, axiod[i]), -999);
                end else begin
                    e = exp_q[i].pop_front();
                    check("data", i, axiod[i] == 8'(e.val), shown(i, axiod[i]), e.val);
                    check("latency", i, cyc == e.due, cyc, e.due);
                    last_out[i] = e.val;
                end
            end else begin
                check("hold", i, axiod[i] == 8'(last_out[i]), shown(i, axiod[i]), last_out[i]);
                if (exp_q[i].size() != 0 && exp_q[i][0].due <= cyc) begin
                    e = exp_q[i].pop_front();
                    check("missing_pulse", i, 1'b0, cyc, e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        axiiv = '0;
        axiid = '0;
        clear_model();
        for (int i = 0; i < N; i++) last_out[i] = 0;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Constant drive and saturation, L=2 rectified.
        repeat (4) send(0, -20);
        idle(3);
        repeat (4) send(0, -128);
        idle(2);
        send(0, 127); send(0, -128); send(0, 0); send(0, 1);
        idle(3);

        // Signed floor average, L=1.
        send(1, -3); send(1, 0);
        idle(2);
        send(1, 5); send(1, 6);
        idle(3);

        // Reset discards a partial block.
        repeat (3) send(0, 10);
        rst = 1'b1;
        clear_model();
        idle(1);
        rst = 1'b0;
        idle(1);
        repeat (4) send(0, 40);
        idle(3);

        // Pass-through, L=0.
        send(3, 5); send(3, -7); send(3, -128);
        idle(3);

        // Default L=8: spaced, long gaps, back-to-back.
        for (int k = 0; k < 256; k++) begin
            send(2, (k % 2 == 0) ? 50 : -50);
            idle(1);
        end
        for (int k = 0; k < 256; k++) begin
            send(2, (k % 2 == 0) ? -50 : 50);
            idle((k == 3 || k == 200) ? 10000 : int'($urandom_range(0, 12)));
        end
        for (int k = 0; k < 512; k++) begin
            send(2, (k < 256) ? ((k % 2 == 0) ? 50 : -50) : int'($urandom_range(0, 255)) - 128);
        end
        idle(3);

        // Randomized blocks on the short configurations.
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < N; i++) begin
                if (i != 2) begin
                    send(i, int'($urandom_range(0, 255)) - 128);
                    if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
                end
            end
        end
        idle(5);

        for (int i = 0; i < N; i++) begin
            check("drained", i, exp_q[i].size() == 0, exp_q[i].size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
